ahb_mem_responder: RTL and testbench
====================================

Name: ahb_mem_responder

Overview:
- AHB-Lite slave memory model that sits on the downstream side of the instruction cache and answers its fetch requests.
- Word-addressed backing store with a configurable wait-state count.
- Supports SINGLE, INCR4 and WRAP4 bursts, both reads and writes.
- Checks burst address sequencing and signals ERROR on protocol or range violations. Used as the next-level memory in simulation and as the on-chip boot ROM/RAM in synthesis.

Parameters:
- MEM_WORDS, 4096, number of 32-bit words; power of two.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; must be aligned to MEM_WORDS*4.
- WAIT_STATES, 1, hreadyout-low cycles inserted per data phase (0..15).

Ports:
- hclk  in  1  clock; all logic on rising edge.
- hrst  in  1  synchronous, active-high reset.
- hsel  in  1  slave select.
- haddr  in  32  address-phase byte address.
- hwrite  in  1  1 = write, 0 = read.
- hsize  in  3  transfer size; only 3'b010 (word) is legal.
- hburst  in  3  SINGLE=0, INCR4=3, WRAP4=2; all others are treated as an ERROR.
- htrans  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- hwdata  in  32  write data, valid in the data phase.
- hready  in  1  bus hready (hreadyin).
- hreadyout  out  1  transfer-done / wait indication.
- hrdata  out  32  read data.
- hresp  out  1  0 = OKAY, 1 = ERROR.

Behaviour:
- Reset values: hreadyout=1, hresp=0, hrdata=0, state=IDLE, beat count=0, wait counter=0. Memory contents are not reset.
- Accepting a request:
  - An address phase is accepted on an edge where hsel & hready & htrans[1].
  - On acceptance, latch haddr, hwrite, hburst and the error verdict.
  - With hsel & hready and htrans = IDLE or BUSY, there is no transfer; the next cycle is a zero-wait OKAY.
- Error verdict: ERROR if any of the following holds:
  - hsize != 3'b010
  - haddr[1:0] != 0
  - address outside [BASE_ADDR, BASE_ADDR + MEM_WORDS*4)
  - illegal hburst
  - SEQ with no burst open
  - NONSEQ while a burst is open and unfinished
  - SEQ address != expected address. Expected address for INCR4 is previous + 4. For WRAP4 it is {prev[31:4], prev[3:2] + 1, 2'b00}, i.e. it wraps within the 16-byte block.
- States:
  - IDLE: hreadyout=1, hresp=0.
  - WAIT: hreadyout=0. Entered on acceptance if WAIT_STATES>0; stays there WAIT_STATES cycles, then goes to RESP.
  - RESP: hreadyout=1, hresp=0. Entered directly on acceptance if WAIT_STATES=0.
  - ERR1: hreadyout=0, hresp=1.
  - ERR2: hreadyout=1, hresp=1.
  - An erroneous request goes ERR1 -> ERR2, with no wait states and no memory effect.
- Pipelining:
  - In RESP or ERR2, a new address phase may be accepted on the same edge; the next state then follows the new request.
  - Otherwise RESP and ERR2 return to IDLE.
  - Back-to-back zero-wait beats therefore keep hreadyout=1 continuously.
- Read data:
  - In RESP for a read, hrdata = mem[(addr - BASE_ADDR) >> 2].
  - hrdata is registered: the value is loaded on the edge entering RESP.
  - In all other states hrdata=0.
- Write data: on the edge leaving RESP for a write, mem[word] <= hwdata.
- Bursts:
  - NONSEQ with INCR4 or WRAP4 opens a burst and sets beat count=1.
  - Each accepted SEQ increments the beat count; the burst closes when 4 beats have been accepted.
  - BUSY inside a burst does not change the beat count or the expected address.
  - An ERROR closes any open burst.
- Reset mid-operation: hrst forces IDLE on the next edge; a write in WAIT or RESP is not committed.

Test Plan:
- Reset, then SINGLE read of 0x0000_0010 (mem[4]=0xDEAD_BEEF, WAIT_STATES=1) -> hreadyout low 1 cycle, then high with hrdata=0xDEAD_BEEF, hresp=0.
- WRAP4 read starting at 0x0000_0028, SEQ addresses 0x2C, 0x20, 0x24, WAIT_STATES=0 -> 4 consecutive cycles with hreadyout=1, returning mem[10], mem[11], mem[8], mem[9].
- INCR4 write to 0x100..0x10C with data 1..4, then read back -> mem[64..67] = 1, 2, 3, 4.
- WRAP4 from 0x28 with second SEQ address 0x30 (should be 0x20) -> beat 3 gets ERR1 (hreadyout=0, hresp=1) then ERR2 (hreadyout=1, hresp=1); mem[12] is unchanged.
- Read at BASE_ADDR + MEM_WORDS*4, and a read at 0x2 with hsize=2 -> two-cycle ERROR each; then BUSY mid-INCR4 -> zero-wait OKAY, burst completes normally afterwards.
- Write to 0x40 with WAIT_STATES=3, hrst asserted in the 2nd wait cycle -> hreadyout=1, hrdata=0 next edge; mem[16] keeps its old value.

Source files
------------

// File: rtl/ahb_mem_responder.sv
// AHB-Lite word memory slave: SINGLE/INCR4/WRAP4, wait states, ERROR checks.
// Ports: hclk/hrst, AHB-Lite slave inputs (hsel..hready), hreadyout/hrdata/hresp.
module ahb_mem_responder #(
  parameter int unsigned MEM_WORDS   = 4096,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        hclk,
  input  logic        hrst,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [2:0]  hburst,
  input  logic [1:0]  htrans,
  input  logic [31:0] hwdata,
  input  logic        hready,
  output logic        hreadyout,
  output logic [31:0] hrdata,
  output logic        hresp
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam logic [3:0] WS = 4'(WAIT_STATES);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_RESP, S_ERR1, S_ERR2
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   word_q, word_d;
  logic            write_q, write_d;
  logic [3:0]      wait_q, wait_d;
  logic            open_q, open_d;
  logic [2:0]      beat_q, beat_d;
  logic            wrap_q, wrap_d;
  logic [31:0]     exp_q, exp_d;
  logic [31:0]     rdata_q, rdata_d;
  logic [31:0]     mem_q [MEM_WORDS];

  logic          accept, is_seq, err;
  logic          burst_ok, in_range, commit;
  logic [AW-1:0] rd_word;
  logic          rd_write;

  function automatic logic [31:0] nxt(
    input logic [31:0] a,
    input logic        w
  );
    if (w) nxt = {a[31:4], a[3:2] + 2'd1, 2'b00};
    else   nxt = a + 32'd4;
  endfunction

  assign hreadyout = !(state_q == S_WAIT || state_q == S_ERR1);
  assign hresp     = (state_q == S_ERR1 || state_q == S_ERR2);
  assign hrdata    = rdata_q;

  // Gating with hreadyout keeps a stray hready from overlapping our data phase.
  assign accept   = hsel & hready & htrans[1] & hreadyout;
  assign is_seq   = (htrans == 2'b11);
  assign burst_ok = (hburst == 3'd0) || (hburst == 3'd2) || (hburst == 3'd3);
  // BASE_ADDR is aligned to the window size, so a tag compare suffices.
  assign in_range = (haddr[31:AW+2] == BASE_ADDR[31:AW+2]);

  assign err = (hsize != 3'b010) || (haddr[1:0] != 2'b00) || !in_range
            || !burst_ok || (is_seq && !open_q) || (!is_seq && open_q)
            || (is_seq && open_q && haddr != exp_q);

  assign commit   = (state_q == S_RESP) && write_q;
  assign rd_word  = accept ? haddr[AW+1:2] : word_q;
  assign rd_write = accept ? hwrite : write_q;

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    word_d  = word_q;
    write_d = write_q;
    open_d  = open_q;
    beat_d  = beat_q;
    wrap_d  = wrap_q;
    exp_d   = exp_q;
    rdata_d = 32'd0;

    if (accept) begin
      word_d  = haddr[AW+1:2];
      write_d = hwrite;
      if (err) begin
        open_d = 1'b0;
      end else if (!is_seq) begin
        open_d = (hburst != 3'd0);
        beat_d = 3'd1;
        wrap_d = (hburst == 3'd2);
        exp_d  = nxt(haddr, hburst == 3'd2);
      end else begin
        beat_d = beat_q + 3'd1;
        exp_d  = nxt(haddr, wrap_q);
        if (beat_q == 3'd3) open_d = 1'b0;
      end
    end

    unique case (state_q)
      S_WAIT: begin
        if (wait_q == 4'd0) state_d = S_RESP;
        else                wait_d  = wait_q - 4'd1;
      end
      S_ERR1: state_d = S_ERR2;
      default: begin
        state_d = S_IDLE;
        if (accept) begin
          if (err) begin
            state_d = S_ERR1;
          end else if (WAIT_STATES == 0) begin
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
            wait_d  = WS - 4'd1;
          end
        end
      end
    endcase

    if (state_d == S_RESP && !rd_write) begin
      // Forward a write retiring on this same edge to the same word.
      if (commit && rd_word == word_q) rdata_d = hwdata;
      else                             rdata_d = mem_q[rd_word];
    end
  end

  always_ff @(posedge hclk) begin
    if (hrst) begin
      state_q <= S_IDLE;
      wait_q  <= 4'd0;
      word_q  <= '0;
      write_q <= 1'b0;
      open_q  <= 1'b0;
      beat_q  <= 3'd0;
      wrap_q  <= 1'b0;
      exp_q   <= 32'd0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      word_q  <= word_d;
      write_q <= write_d;
      open_q  <= open_d;
      beat_q  <= beat_d;
      wrap_q  <= wrap_d;
      exp_q   <= exp_d;
      rdata_q <= rdata_d;
    end
  end

  always_ff @(posedge hclk) begin
    if (!hrst && commit) mem_q[word_q] <= hwdata;
  end

endmodule

// File: tb/tb_ahb_mem_responder.sv
// Directed bench for ahb_mem_responder.
// Three instances share the bus: WAIT_STATES 1, 0 and 3.
module tb_ahb_mem_responder;

  logic        clk = 1'b0;
  logic        hrst;
  logic        hsel, hwrite, hready;
  logic [31:0] haddr, hwdata;
  logic [2:0]  hsize, hburst;
  logic [1:0]  htrans;
  logic [1:0]  sel;
  logic        ho0, ho1, ho2, rs0, rs1, rs2;
  logic [31:0] rd0, rd1, rd2;
  logic        ho_b, rs_b;
  logic [31:0] rd_b;
  int          checks = 0;
  int          failures = 0;

  logic        f_ho1, f_rs1, f_rs;
  int          f_waits;
  logic [31:0] f_rd;

  always #5 clk = ~clk;

  always_comb begin
    ho_b = ho0; rs_b = rs0; rd_b = rd0;
    if (sel == 2'd1) begin ho_b = ho1; rs_b = rs1; rd_b = rd1; end
    if (sel == 2'd2) begin ho_b = ho2; rs_b = rs2; rd_b = rd2; end
  end
  assign hready = ho_b;

  ahb_mem_responder #(.WAIT_STATES(1)) u0 (
    .hclk(clk), .hrst(hrst), .hsel(hsel && sel == 2'd0), .haddr(haddr),
    .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .htrans(htrans),
    .hwdata(hwdata), .hready(hready), .hreadyout(ho0), .hrdata(rd0),
    .hresp(rs0));
  ahb_mem_responder #(.WAIT_STATES(0)) u1 (
    .hclk(clk), .hrst(hrst), .hsel(hsel && sel == 2'd1), .haddr(haddr),
    .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .htrans(htrans),
    .hwdata(hwdata), .hready(hready), .hreadyout(ho1), .hrdata(rd1),
    .hresp(rs1));
  ahb_mem_responder #(.WAIT_STATES(3)) u2 (
    .hclk(clk), .hrst(hrst), .hsel(hsel && sel == 2'd2), .haddr(haddr),
    .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .htrans(htrans),
    .hwdata(hwdata), .hready(hready), .hreadyout(ho2), .hrdata(rd2),
    .hresp(rs2));

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic aph(input logic [1:0] tr, input logic w,
                     input logic [31:0] a, input logic [2:0] b,
                     input logic [2:0] sz);
    hsel = (tr != 2'b00);
    htrans = tr;
    hwrite = w;
    haddr = a;
    hburst = b;
    hsize = sz;
  endtask

  task automatic xfer(input logic w, input logic [31:0] a,
                      input logic [31:0] wd, input logic [2:0] b,
                      input logic [2:0] sz);
    aph(2'b10, w, a, b, sz);
    cyc();
    aph(2'b00, 1'b0, 32'd0, 3'd0, 3'b010);
    hwdata = wd;
    f_ho1 = ho_b;
    f_rs1 = rs_b;
    f_waits = 0;
    while (!ho_b && f_waits < 20) begin
      f_waits++;
      cyc();
    end
    f_rd = rd_b;
    f_rs = rs_b;
    cyc();
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d,
                    input int ws);
    xfer(1'b1, a, d, 3'd0, 3'b010);
    chk("wr_waits", f_waits, ws);
    chk("wr_resp", {31'd0, f_rs}, 32'd0);
  endtask

  task automatic rdc(input string tag, input logic [31:0] a,
                     input logic [31:0] exp, input int ws);
    xfer(1'b0, a, 32'd0, 3'd0, 3'b010);
    chk({tag, "_waits"}, f_waits, ws);
    chk({tag, "_resp"}, {31'd0, f_rs}, 32'd0);
    chk(tag, f_rd, exp);
  endtask

  task automatic errc(input string tag, input logic [31:0] a,
                      input logic [2:0] b, input logic [2:0] sz);
    xfer(1'b0, a, 32'd0, b, sz);
    chk({tag, "_ho1"}, {31'd0, f_ho1}, 32'd0);
    chk({tag, "_rs1"}, {31'd0, f_rs1}, 32'd1);
    chk({tag, "_waits"}, f_waits, 1);
    chk({tag, "_rs2"}, {31'd0, f_rs}, 32'd1);
  endtask

  initial begin
    sel = 2'd0;
    hrst = 1'b1;
    hwdata = 32'd0;
    aph(2'b00, 1'b0, 32'd0, 3'd0, 3'b010);
    cyc();
    cyc();
    hrst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sel = 2'(i);
      #1;
      chk("rst_hready", {31'd0, ho_b}, 32'd1);
      chk("rst_hresp", {31'd0, rs_b}, 32'd0);
      chk("rst_hrdata", rd_b, 32'd0);
    end

    // SINGLE read, one wait state
    sel = 2'd0;
    wr(32'h10, 32'hDEAD_BEEF, 1);
    xfer(1'b0, 32'h10, 32'd0, 3'd0, 3'b010);
    chk("t1_wait_low", {31'd0, f_ho1}, 32'd0);
    chk("t1_waits", f_waits, 1);
    chk("t1_rdata", f_rd, 32'hDEAD_BEEF);
    chk("t1_resp", {31'd0, f_rs}, 32'd0);

    // WRAP4 read, zero wait
    sel = 2'd1;
    wr(32'h20, 32'hA000_0008, 0);
    wr(32'h24, 32'hA000_0009, 0);
    wr(32'h28, 32'hA000_000A, 0);
    wr(32'h2C, 32'hA000_000B, 0);
    wr(32'h30, 32'hC0FF_EE12, 0);
    aph(2'b10, 1'b0, 32'h28, 3'd2, 3'b010);
    cyc();
    chk("w4_b0_rdy", {31'd0, ho_b}, 32'd1);
    chk("w4_b0", rd_b, 32'hA000_000A);
    aph(2'b11, 1'b0, 32'h2C, 3'd2, 3'b010);
    cyc();
    chk("w4_b1_rdy", {31'd0, ho_b}, 32'd1);
    chk("w4_b1", rd_b, 32'hA000_000B);
    aph(2'b11, 1'b0, 32'h20, 3'd2, 3'b010);
    cyc();
    chk("w4_b2_rdy", {31'd0, ho_b}, 32'd1);
    chk("w4_b2", rd_b, 32'hA000_0008);
    aph(2'b11, 1'b0, 32'h24, 3'd2, 3'b010);
    cyc();
    chk("w4_b3_rdy", {31'd0, ho_b}, 32'd1);
    chk("w4_b3", rd_b, 32'hA000_0009);
    chk("w4_b3_resp", {31'd0, rs_b}, 32'd0);
    aph(2'b00, 1'b0, 32'd0, 3'd0, 3'b010);
    cyc();

    // INCR4 write 1..4, then read back
    aph(2'b10, 1'b1, 32'h100, 3'd3, 3'b010);
    cyc();
    for (int i = 1; i <= 4; i++) begin
      chk("i4w_rdy", {31'd0, ho_b}, 32'd1);
      chk("i4w_resp", {31'd0, rs_b}, 32'd0);
      hwdata = 32'(i);
      if (i < 4) aph(2'b11, 1'b1, 32'h100 + 32'(4 * i), 3'd3, 3'b010);
      else       aph(2'b00, 1'b0, 32'd0, 3'd0, 3'b010);
      cyc();
    end
    rdc("i4_rb0", 32'h100, 32'd1, 0);
    rdc("i4_rb1", 32'h104, 32'd2, 0);
    rdc("i4_rb2", 32'h108, 32'd3, 0);
    rdc("i4_rb3", 32'h10C, 32'd4, 0);

    // WRAP4 write with a bad third address
    aph(2'b10, 1'b1, 32'h28, 3'd2, 3'b010);
    cyc();
    hwdata = 32'h5151_0000;
    aph(2'b11, 1'b1, 32'h2C, 3'd2, 3'b010);
    cyc();
    hwdata = 32'h5151_0001;
    aph(2'b11, 1'b1, 32'h30, 3'd2, 3'b010);
    cyc();
    chk("seqerr_ho1", {31'd0, ho_b}, 32'd0);
    chk("seqerr_rs1", {31'd0, rs_b}, 32'd1);
    aph(2'b00, 1'b0, 32'd0, 3'd0, 3'b010);
    hwdata = 32'h5151_0002;
    cyc();
    chk("seqerr_ho2", {31'd0, ho_b}, 32'd1);
    chk("seqerr_rs2", {31'd0, rs_b}, 32'd1);
    cyc();
    chk("seqerr_idle_rs", {31'd0, rs_b}, 32'd0);
    rdc("seqerr_m12", 32'h30, 32'hC0FF_EE12, 0);
    rdc("seqerr_m10", 32'h28, 32'h5151_0000, 0);
    rdc("seqerr_m11", 32'h2C, 32'h5151_0001, 0);

    // Range, alignment/size and burst-type errors
    errc("range", 32'h0000_4000, 3'd0, 3'b010);
    errc("unalign", 32'h2, 3'd0, 3'b010);
    errc("size", 32'h8, 3'd0, 3'b001);
    errc("hburst", 32'h8, 3'd1, 3'b010);

    // BUSY inside INCR4 read
    aph(2'b10, 1'b0, 32'h100, 3'd3, 3'b010);
    cyc();
    chk("busy_b0", rd_b, 32'd1);
    aph(2'b11, 1'b0, 32'h104, 3'd3, 3'b010);
    cyc();
    chk("busy_b1", rd_b, 32'd2);
    aph(2'b01, 1'b0, 32'h108, 3'd3, 3'b010);
    cyc();
    chk("busy_rdy", {31'd0, ho_b}, 32'd1);
    chk("busy_resp", {31'd0, rs_b}, 32'd0);
    chk("busy_rdata", rd_b, 32'd0);
    aph(2'b11, 1'b0, 32'h108, 3'd3, 3'b010);
    cyc();
    chk("busy_b2", rd_b, 32'd3);
    chk("busy_b2_resp", {31'd0, rs_b}, 32'd0);
    aph(2'b11, 1'b0, 32'h10C, 3'd3, 3'b010);
    cyc();
    chk("busy_b3", rd_b, 32'd4);
    chk("busy_b3_resp", {31'd0, rs_b}, 32'd0);
    aph(2'b00, 1'b0, 32'd0, 3'd0, 3'b010);
    cyc();
    rdc("after_burst", 32'h104, 32'd2, 0);

    // Reset during a three-wait-state write
    sel = 2'd2;
    wr(32'h40, 32'h5555_AAAA, 3);
    aph(2'b10, 1'b1, 32'h40, 3'd0, 3'b010);
    cyc();
    aph(2'b00, 1'b0, 32'd0, 3'd0, 3'b010);
    hwdata = 32'h1234_5678;
    chk("rstw_w1", {31'd0, ho_b}, 32'd0);
    cyc();
    chk("rstw_w2", {31'd0, ho_b}, 32'd0);
    hrst = 1'b1;
    cyc();
    chk("rstw_rdy", {31'd0, ho_b}, 32'd1);
    chk("rstw_rdata", rd_b, 32'd0);
    chk("rstw_resp", {31'd0, rs_b}, 32'd0);
    hrst = 1'b0;
    cyc();
    rdc("rstw_m16", 32'h40, 32'h5555_AAAA, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
